// File: rtl/control_incendio_pkg.sv
// Shared types and constants for the fire-suppression supervisor and the
// control-word memory it addresses.
package control_incendio_pkg;

  // Supervisor states; the encoding is exported on the estado port.
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    VERIFICA = 2'd1,
    INCENDIO = 2'd2,
    ENFRIA   = 2'd3
  } estado_t;

  // Control-word memory addresses.
  localparam logic DIR_REPOSO    = 1'b0;
  localparam logic DIR_EXTINCION = 1'b1;

  // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
  function automatic int ancho_contador(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/control_incendio_antirrebote.sv
// antirrebote: two-flop synchronizer followed by a debouncer. The filtered
// output changes only after DEB_CICLOS consecutive synchronized samples that
// differ from the current filtered value.
module control_incendio_antirrebote #(
  parameter int DEB_CICLOS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic entrada,
  output logic filtrada
);

  localparam int CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CICLOS - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous raw input into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= entrada;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (sync2_reg == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_FIN) begin
      filt_reg <= sync2_reg;
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign filtrada = filt_reg;

endmodule

// File: rtl/control_incendio.sv
// control_incendio: sensor-supervision FSM for the fire-suppression controller.
// Filters smoke/temperature inputs, confirms fire, holds suppression through a
// cool-down window and drives the control-word memory address.
// Optional feature macro: PARO_MANUAL_EN (manual stop button with lockout).
module control_incendio
  import control_incendio_pkg::*;
#(
  parameter int DEB_CICLOS  = 16,
  parameter int CONF_CICLOS = 50,
  parameter int HOLD_CICLOS = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_humo,
  input  logic       sensor_temp,
  input  logic       boton_paro,
  output logic       adress,
  output logic       alarma,
  output logic [1:0] estado
);

  localparam int CW = ancho_contador(CONF_CICLOS, HOLD_CICLOS);
  localparam logic [CW-1:0] CONF_FIN = CW'(CONF_CICLOS - 1);
  localparam logic [CW-1:0] HOLD_FIN = CW'(HOLD_CICLOS - 1);

  logic [1:0]    sensor_raw;
  logic [1:0]    sensor_filt;
  logic          det;
  logic          paro_flanco;
  logic          inhibe;

  estado_t       estado_reg;
  estado_t       estado_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign sensor_raw = {sensor_temp, sensor_humo};

  // One synchronizer/debouncer per sensor (bit 0 humo, bit 1 temp).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      control_incendio_antirrebote #(
        .DEB_CICLOS(DEB_CICLOS)
      ) u_antirrebote (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (sensor_raw[gi]),
        .filtrada(sensor_filt[gi])
      );
    end
  endgenerate

  assign det = |sensor_filt;

`ifdef PARO_MANUAL_EN
  logic paro_filt;
  logic paro_prev_reg;
  logic bloqueo_reg;

  control_incendio_antirrebote #(
    .DEB_CICLOS(DEB_CICLOS)
  ) u_antirrebote_paro (
    .clk     (clk),
    .reset_n (reset_n),
    .entrada (boton_paro),
    .filtrada(paro_filt)
  );

  assign paro_flanco = paro_filt & ~paro_prev_reg;
  assign inhibe      = bloqueo_reg;

  // Button edge detection and lockout: a press locks out re-arming until det clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paro_prev_reg <= 1'b0;
      bloqueo_reg   <= 1'b0;
    end else begin
      paro_prev_reg <= paro_filt;
      if (paro_flanco)
        bloqueo_reg <= 1'b1;
      else if (!det)
        bloqueo_reg <= 1'b0;
    end
  end
`else
  logic unused_paro;
  assign unused_paro = boton_paro;
  assign paro_flanco = 1'b0;
  assign inhibe      = 1'b0;
`endif

  // State and shared counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_reg <= NORMAL;
      cnt_reg    <= '0;
    end else begin
      estado_reg <= estado_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic; the counter is cleared on every state entry.
  always_comb begin
    estado_next = estado_reg;
    cnt_next    = cnt_reg;
    unique case (estado_reg)
      NORMAL: begin
        if (det && !inhibe) begin
          estado_next = VERIFICA;
          cnt_next    = '0;
        end
      end
      VERIFICA: begin
        if (!det) begin
          estado_next = NORMAL;
          cnt_next    = '0;
        end else if (cnt_reg == CONF_FIN) begin
          estado_next = INCENDIO;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      INCENDIO: begin
        if (!det) begin
          estado_next = ENFRIA;
          cnt_next    = '0;
        end
      end
      ENFRIA: begin
        if (det) begin
          estado_next = INCENDIO;
          cnt_next    = '0;
        end else if (cnt_reg == HOLD_FIN) begin
          estado_next = NORMAL;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        estado_next = NORMAL;
        cnt_next    = '0;
      end
    endcase
    // Manual stop overrides every other transition.
    if (paro_flanco) begin
      estado_next = NORMAL;
      cnt_next    = '0;
    end
  end

  // Outputs decoded purely from the state register.
  always_comb begin
    adress = ((estado_reg == INCENDIO) || (estado_reg == ENFRIA)) ? DIR_EXTINCION : DIR_REPOSO;
    alarma = (estado_reg != NORMAL);
    estado = estado_reg;
  end

endmodule

// File: tb/tb_control_incendio.sv
// Directed testbench for control_incendio (default parameters DEB=16,
// CONF=50, HOLD=100). Inputs change and outputs are sampled on the falling edge.
module tb_control_incendio;

  logic       clk;
  logic       reset_n;
  logic       sensor_humo;
  logic       sensor_temp;
  logic       boton_paro;
  logic       adress;
  logic       alarma;
  logic [1:0] estado;

  int total;
  int bad;

  control_incendio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sensor_humo(sensor_humo),
    .sensor_temp(sensor_temp),
    .boton_paro (boton_paro),
    .adress     (adress),
    .alarma     (alarma),
    .estado     (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int errs;
    #2;
    total++;
    if (estado !== 2'd0 || adress !== 1'b0 || alarma !== 1'b0) begin
      bad++;
      $display("FAIL reset_in: estado=%0d adress=%0d alarma=%0d want 0/0/0", estado, adress, alarma);
    end
    tick(3);
    reset_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (adress !== 1'b0 || estado !== 2'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_500: %0d cycles with adress/estado nonzero, want 0", errs);
    end
    $display("reset: idle 500 cycles checked");
  endtask

  task automatic test_glitch();
    int errs;
    errs = 0;
    sensor_humo = 1'b1;
    tick(10);
    sensor_humo = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (alarma !== 1'b0 || estado !== 2'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL glitch: %0d cycles with alarma/estado nonzero, want 0", errs);
    end
    $display("glitch: humo 10-cycle pulse ignored");
  endtask

  task automatic test_incendio_ciclo();
    sensor_temp = 1'b1;
    tick(18);
    total++;
    if (estado !== 2'd0) begin bad++; $display("FAIL verifica_early: estado=%0d want 0", estado); end
    tick(1);
    total++;
    if (estado !== 2'd1 || alarma !== 1'b1 || adress !== 1'b0) begin
      bad++; $display("FAIL verifica_entry: estado=%0d alarma=%0d adress=%0d want 1/1/0", estado, alarma, adress);
    end
    tick(49);
    total++;
    if (estado !== 2'd1) begin bad++; $display("FAIL confirm_early: estado=%0d want 1", estado); end
    tick(1);
    total++;
    if (estado !== 2'd2 || adress !== 1'b1 || alarma !== 1'b1) begin
      bad++; $display("FAIL incendio_entry: estado=%0d adress=%0d alarma=%0d want 2/1/1", estado, adress, alarma);
    end
    $display("incendio: temp held, VERIFICA at 19, INCENDIO 50 later");
    sensor_temp = 1'b0;
    tick(18);
    total++;
    if (estado !== 2'd2) begin bad++; $display("FAIL enfria_early: estado=%0d want 2", estado); end
    tick(1);
    total++;
    if (estado !== 2'd3 || adress !== 1'b1 || alarma !== 1'b1) begin
      bad++; $display("FAIL enfria_entry: estado=%0d adress=%0d alarma=%0d want 3/1/1", estado, adress, alarma);
    end
    // Re-raise so det returns at cool-down cycle 60.
    tick(41);
    sensor_temp = 1'b1;
    tick(18);
    total++;
    if (estado !== 2'd3) begin bad++; $display("FAIL rearm_early: estado=%0d want 3", estado); end
    tick(1);
    total++;
    if (estado !== 2'd2 || adress !== 1'b1) begin
      bad++; $display("FAIL rearm_incendio: estado=%0d adress=%0d want 2/1", estado, adress);
    end
    $display("enfria: reassert at cool-down cycle 60 returns to INCENDIO");
    sensor_temp = 1'b0;
    tick(19);
    total++;
    if (estado !== 2'd3) begin bad++; $display("FAIL enfria2_entry: estado=%0d want 3", estado); end
    tick(99);
    total++;
    if (estado !== 2'd3 || adress !== 1'b1) begin
      bad++; $display("FAIL hold_early: estado=%0d adress=%0d want 3/1", estado, adress);
    end
    tick(1);
    total++;
    if (estado !== 2'd0 || adress !== 1'b0 || alarma !== 1'b0) begin
      bad++; $display("FAIL hold_done: estado=%0d adress=%0d alarma=%0d want 0/0/0", estado, adress, alarma);
    end
    $display("enfria: NORMAL exactly 100 cycles after ENFRIA entry");
  endtask

  task automatic test_verifica_abort();
    sensor_humo = 1'b1;
    tick(19);
    total++;
    if (estado !== 2'd1) begin bad++; $display("FAIL abort_verifica: estado=%0d want 1", estado); end
    sensor_humo = 1'b0;
    tick(18);
    total++;
    if (estado !== 2'd1) begin bad++; $display("FAIL abort_early: estado=%0d want 1", estado); end
    tick(1);
    total++;
    if (estado !== 2'd0 || alarma !== 1'b0) begin
      bad++; $display("FAIL abort_normal: estado=%0d alarma=%0d want 0/0", estado, alarma);
    end
    $display("abort: det lost in VERIFICA returns to NORMAL");
  endtask

  task automatic test_reset_async();
    sensor_temp = 1'b1;
    tick(69);
    total++;
    if (estado !== 2'd2 || adress !== 1'b1) begin
      bad++; $display("FAIL async_pre: estado=%0d adress=%0d want 2/1", estado, adress);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (adress !== 1'b0 || estado !== 2'd0 || alarma !== 1'b0) begin
      bad++; $display("FAIL async_reset: adress=%0d estado=%0d alarma=%0d want 0/0/0", adress, estado, alarma);
    end
    sensor_temp = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    total++;
    if (estado !== 2'd0) begin bad++; $display("FAIL async_after: estado=%0d want 0", estado); end
    $display("async reset: adress dropped without clock edge");
  endtask

`ifdef PARO_MANUAL_EN
  task automatic test_paro();
    sensor_humo = 1'b1;
    tick(69);
    total++;
    if (estado !== 2'd2) begin bad++; $display("FAIL paro_pre: estado=%0d want 2", estado); end
    boton_paro = 1'b1;
    tick(18);
    total++;
    if (estado !== 2'd2) begin bad++; $display("FAIL paro_early: estado=%0d want 2", estado); end
    tick(1);
    total++;
    if (estado !== 2'd0 || adress !== 1'b0) begin
      bad++; $display("FAIL paro_stop: estado=%0d adress=%0d want 0/0", estado, adress);
    end
    boton_paro = 1'b0;
    tick(40);
    total++;
    if (estado !== 2'd0) begin bad++; $display("FAIL paro_lock: estado=%0d want 0", estado); end
    sensor_humo = 1'b0;
    tick(25);
    sensor_humo = 1'b1;
    tick(19);
    total++;
    if (estado !== 2'd1) begin bad++; $display("FAIL paro_rearm: estado=%0d want 1", estado); end
    sensor_humo = 1'b0;
    tick(25);
    $display("paro: manual stop forces NORMAL and locks until smoke clears");
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    sensor_humo = 1'b0;
    sensor_temp = 1'b0;
    boton_paro  = 1'b0;
    test_reset();
    test_glitch();
    test_incendio_ciclo();
    test_verifica_abort();
    test_reset_async();
`ifdef PARO_MANUAL_EN
    test_paro();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
